// File: rtl/cic_pkg.sv
// cic_pkg: shared helpers for the CIC decimator.
//   clog2      - ceiling log2 used for port and counter sizing
//   acc_w      - accumulator width that makes integrator wrap-around harmless
//   round_sat  - round-half-up arithmetic shift followed by signed saturation
package cic_pkg;

  localparam int unsigned WIDE_W = 128;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned acc_w(input int unsigned in_w,
                                        input int unsigned order,
                                        input int unsigned rlog_max);
    return in_w + order * rlog_max;
  endfunction

  // x is the sign-extended comb output; the result fits in out_w signed bits.
  function automatic logic signed [WIDE_W-1:0] round_sat(
      input logic signed [WIDE_W-1:0] x,
      input int unsigned              s,
      input int unsigned              out_w);
    logic signed [WIDE_W-1:0] r;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    r = x;
    if (s != 0) r = (x + (128'sd1 <<< (s - 1))) >>> s;
    hi = (128'sd1 <<< (out_w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (out_w - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one M=1 comb section. On a token it outputs x - x_prev and
// remembers x; the token is forwarded one cycle later with the result.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clr_i         synchronous clear (flush)
//   tok_i, x_i    incoming token and sample
//   tok_o, y_o    outgoing token and difference
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int unsigned ACC_W = acc_w(24, 5, 6)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    tok_i,
  input  logic signed [ACC_W-1:0] x_i,
  output logic                    tok_o,
  output logic signed [ACC_W-1:0] y_o
);

  logic signed [ACC_W-1:0] prev_q;
  logic signed [ACC_W-1:0] y_q;
  logic                    tok_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= '0;
      y_q    <= '0;
      tok_q  <= 1'b0;
    end else if (clr_i) begin
      prev_q <= '0;
      y_q    <= '0;
      tok_q  <= 1'b0;
    end else begin
      tok_q <= tok_i;
      if (tok_i) begin
        y_q    <= x_i - prev_q;
        prev_q <= x_i;
      end
    end
  end

  assign tok_o = tok_q;
  assign y_o   = y_q;

endmodule

// File: rtl/cic_decim.sv
// cic_decim: parametrised CIC decimator with runtime power-of-two ratio,
// one-word output holding register with valid/ready, sticky overrun, flush.
//   clk, rst              clock, asynchronous active-high reset
//   in_valid, in_data     input samples (no backpressure)
//   rate_log2, flush      flush clears state and latches the clamped ratio
//   out_data, out_valid   decimated word, held until out_ready
//   out_ready             downstream accept
//   overrun               sticky: a word was dropped while one was pending
module cic_decim
  import cic_pkg::*;
#(
  parameter int unsigned IN_W     = 24,
  parameter int unsigned OUT_W    = 24,
  parameter int unsigned ORDER    = 5,
  parameter int unsigned RLOG_MAX = 6,
  parameter int unsigned RLOG_DEF = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic signed [IN_W-1:0]              in_data,
  input  logic [clog2(RLOG_MAX+1)-1:0]        rate_log2,
  input  logic                                flush,
  output logic signed [OUT_W-1:0]             out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                overrun
);

  localparam int unsigned ACC_W = acc_w(IN_W, ORDER, RLOG_MAX);
  localparam int unsigned RW    = clog2(RLOG_MAX + 1);

  logic [RW-1:0]           rlog_q;
  logic [RW-1:0]           rate_c;
  logic [RLOG_MAX-1:0]     phase_q;
  logic                    phase_last;
  logic                    tok_q;
  logic signed [ACC_W-1:0] integ_q [ORDER];
  logic signed [ACC_W-1:0] integ_d [ORDER];

  logic                    ctok [ORDER+1];
  logic signed [ACC_W-1:0] cdat [ORDER+1];

  logic signed [OUT_W-1:0] sc_q;
  logic signed [OUT_W-1:0] sc_d;
  logic                    sc_vld_q;
  logic signed [OUT_W-1:0] out_q;
  logic                    ovld_q;
  logic                    ovr_q;
  int unsigned             shift;

  always_comb begin
    rate_c = rate_log2;
    if (rate_log2 == '0)                rate_c = RW'(1);
    else if (32'(rate_log2) > RLOG_MAX) rate_c = RW'(RLOG_MAX);
  end

  assign phase_last = (phase_q == RLOG_MAX'((64'd1 << rlog_q) - 64'd1));

  // Integrator cascade is ripple-through: stage k adds stage k-1's new value.
  always_comb begin
    logic signed [ACC_W-1:0] run;
    run = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    for (int unsigned k = 0; k < ORDER; k++) begin
      run        = integ_q[k] + run;
      integ_d[k] = in_valid ? run : integ_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rlog_q  <= RW'(RLOG_DEF);
      phase_q <= '0;
      tok_q   <= 1'b0;
      for (int unsigned k = 0; k < ORDER; k++) integ_q[k] <= '0;
    end else if (flush) begin
      rlog_q  <= rate_c;
      phase_q <= '0;
      tok_q   <= 1'b0;
      for (int unsigned k = 0; k < ORDER; k++) integ_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < ORDER; k++) integ_q[k] <= integ_d[k];
      tok_q <= in_valid && phase_last;
      if (in_valid) phase_q <= phase_last ? '0 : phase_q + RLOG_MAX'(1);
    end
  end

  // The registered last integrator feeds the comb chain alongside tok_q.
  assign ctok[0] = tok_q;
  assign cdat[0] = integ_q[ORDER-1];

  for (genvar g = 0; g < ORDER; g++) begin : g_comb
    cic_comb_stage #(.ACC_W(ACC_W)) u_comb (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (flush),
      .tok_i (ctok[g]),
      .x_i   (cdat[g]),
      .tok_o (ctok[g+1]),
      .y_o   (cdat[g+1])
    );
  end

  always_comb begin
    shift = ORDER * 32'(rlog_q) + IN_W - OUT_W;
    sc_d  = OUT_W'(round_sat({{(WIDE_W-ACC_W){cdat[ORDER][ACC_W-1]}}, cdat[ORDER]},
                             shift, OUT_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_q     <= '0;
      sc_vld_q <= 1'b0;
      out_q    <= '0;
      ovld_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else if (flush) begin
      sc_q     <= '0;
      sc_vld_q <= 1'b0;
      out_q    <= '0;
      ovld_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sc_vld_q <= ctok[ORDER];
      if (ctok[ORDER]) sc_q <= sc_d;
      if (sc_vld_q && (!ovld_q || out_ready)) begin
        out_q  <= sc_q;
        ovld_q <= 1'b1;
      end else if (sc_vld_q) begin
        ovr_q <= 1'b1;
      end else if (ovld_q && out_ready) begin
        ovld_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_q;
  assign out_valid = ovld_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_cic_decim.sv
module tb_cic_decim;

  localparam int unsigned IN_W     = 24;
  localparam int unsigned OUT_W    = 24;
  localparam int unsigned ORDER    = 5;
  localparam int unsigned RLOG_MAX = 6;
  localparam int unsigned RLOG_DEF = 4;
  localparam int unsigned ACC_W    = IN_W + ORDER * RLOG_MAX;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic signed [IN_W-1:0]  in_data = '0;
  logic [2:0]              rate_log2 = 3'd4;
  logic                    flush = 1'b0;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic                    overrun;

  cic_decim #(
    .IN_W(IN_W), .OUT_W(OUT_W), .ORDER(ORDER), .RLOG_MAX(RLOG_MAX), .RLOG_DEF(RLOG_DEF)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .rate_log2(rate_log2), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic signed [OUT_W-1:0] val;
    bit                      chk;
    bit                      per;
  } exp_t;
  exp_t sb[$];
  int unsigned last_xfer = 0;

  task automatic check(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever both are high.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got %0d expected no word", out_data);
      end else begin
        e = sb.pop_front();
        if (e.chk) check("word", longint'(out_data), longint'(e.val));
        if (e.per) check("period", longint'(cyc - last_xfer), 16);
      end
      last_xfer = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input logic signed [IN_W-1:0] v);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = v;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_flush(input logic [2:0] r);
    rate_log2 = r;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
  endtask

  // Words from settle_from onward carry the hand-computed steady-state value.
  task automatic push_dc(input int n, input int settle_from,
                         input logic signed [OUT_W-1:0] v, input bit per);
    for (int w = 1; w <= n; w++)
      sb.push_back('{val: v, chk: (w >= settle_from), per: (per && w >= 2)});
  endtask

  task automatic feed_lat(input int n, input logic signed [IN_W-1:0] v, input string nm);
    int unsigned p;
    int          lat;
    bit          seen;
    lat = 0;
    feed(n, v);
    p    = cyc;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        lat  = int'(cyc - p);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s: got no word expected latency %0d", nm, ORDER + 2);
    end else begin
      check(nm, lat, ORDER + 2);
    end
  endtask

  // Golden modulo-2^ACC_W model for the random run (L = RLOG_MAX).
  logic signed [ACC_W-1:0] mi [ORDER];
  logic signed [ACC_W-1:0] mc [ORDER];

  task automatic model_step(input logic signed [IN_W-1:0] x, input int ph);
    logic signed [ACC_W-1:0] run;
    logic signed [ACC_W-1:0] t;
    logic signed [ACC_W-1:0] d;
    longint                  y;
    run = ACC_W'(x);
    for (int k = 0; k < ORDER; k++) begin
      mi[k] = mi[k] + run;
      run   = mi[k];
    end
    if (ph == (1 << RLOG_MAX) - 1) begin
      t = mi[ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
        d     = t - mc[k];
        mc[k] = t;
        t     = d;
      end
      y = (longint'(t) + (64'sd1 <<< (ORDER * RLOG_MAX - 1))) >>> (ORDER * RLOG_MAX);
      if (y > 8388607)       y = 8388607;
      else if (y < -8388608) y = -8388608;
      sb.push_back('{val: OUT_W'(y), chk: 1'b1, per: 1'b0});
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_data", out_data, 0);
    rst = 1'b0;
    tick();

    // DC gain at the reset-default ratio (L = 4)
    out_ready = 1'b1;
    push_dc(8, 6, 24'sd1000, 1'b1);
    feed(128, 24'sd1000);
    idle(12);

    // Full scale, both polarities
    do_flush(3'd4);
    push_dc(8, 6, 24'sd8388607, 1'b1);
    feed(128, 24'sd8388607);
    idle(12);
    do_flush(3'd4);
    push_dc(8, 6, -24'sd8388608, 1'b1);
    feed(128, -24'sd8388608);
    idle(12);

    // Backpressure: hold word 9, drop word 10
    do_flush(3'd4);
    push_dc(8, 6, 24'sd1000, 1'b1);
    feed(128, 24'sd1000);
    idle(12);
    out_ready = 1'b0;
    feed(16, 24'sd1000);
    idle(10);
    check("bp_ovr_before", overrun, 0);
    feed(16, 24'sd3000);
    idle(10);
    check("bp_valid_held", out_valid, 1);
    check("bp_data_held", out_data, 1000);
    check("bp_overrun", overrun, 1);
    sb.push_back('{val: 24'sd1000, chk: 1'b1, per: 1'b0});
    out_ready = 1'b1;
    tick();
    check("bp_valid_after", out_valid, 0);
    check("bp_overrun_sticky", overrun, 1);
    idle(4);

    // Flush mid-group with rate change; the flush-cycle sample is discarded
    feed(8, 24'sd5000);
    in_valid  = 1'b1;
    in_data   = 24'sd9999;
    do_flush(3'd6);
    in_valid  = 1'b0;
    check("fl_overrun", overrun, 0);
    check("fl_valid", out_valid, 0);
    check("fl_data", out_data, 0);
    push_dc(7, 6, 24'sd1000, 1'b0);
    feed_lat(64, 24'sd1000, "lat64");
    feed(64 * 6, 24'sd1000);
    idle(12);

    // Asynchronous reset mid-stream, then first-word latency at RLOG_DEF
    do_flush(3'd4);
    out_ready = 1'b0;
    feed(48, 24'sd1000);
    idle(12);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_overrun", overrun, 1);
    rate_log2 = 3'd6;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_overrun", overrun, 0);
    check("async_rst_data", out_data, 0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    push_dc(3, 99, '0, 1'b0);
    feed_lat(16, 24'sd1000, "lat16");
    feed(32, 24'sd1000);
    idle(12);

    // Random data with wrap-around at L = RLOG_MAX against the golden model
    do_flush(3'(RLOG_MAX));
    for (int k = 0; k < ORDER; k++) begin
      mi[k] = '0;
      mc[k] = '0;
    end
    for (int i = 0; i < 64 * 40; i++) begin
      logic signed [IN_W-1:0] x;
      x = IN_W'($urandom);
      if (i % 9 == 0) x = (i % 18 == 0) ? 24'sh7FFFFF : 24'sh800000;
      model_step(x, i % 64);
      in_valid = 1'b1;
      in_data  = x;
      tick();
    end
    in_valid = 1'b0;
    idle(12);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
